// File: rtl/conv1d_mc_if.sv
// conv1d_mc_if: CFU command/response bundle.
// Master drives commands; slave returns ret and output_buffer_valid.
interface conv1d_mc_if;
  logic [6:0]  cmd;
  logic [31:0] inp0;
  logic [31:0] inp1;
  logic        output_buffer_valid;
  logic [31:0] ret;

  modport master (
    output cmd, inp0, inp1,
    input  output_buffer_valid, ret
  );

  modport slave (
    input  cmd, inp0, inp1,
    output output_buffer_valid, ret
  );
endinterface

// File: rtl/conv1d_mc.sv
// conv1d_mc: multi-channel int8 1-D convolution CFU.
// Command-loaded buffers and config feed a MAC/STORE sequencer.
module conv1d_mc #(
  parameter int MAX_LEN    = 64,
  parameter int KERNEL_LEN = 8,
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32
) (
  input logic        clk,
  input logic        reset,
  conv1d_mc_if.slave bus
);
  localparam int IW = NUM_CH * MAX_LEN / 4;
  localparam int KW = NUM_CH * KERNEL_LEN / 4;
  localparam int OW = MAX_LEN - KERNEL_LEN + 1;
  localparam int IA = (IW > 1) ? $clog2(IW) : 1;
  localparam int KA = (KW > 1) ? $clog2(KW) : 1;
  localparam int OA = (OW > 1) ? $clog2(OW) : 1;

  typedef enum logic [1:0] {
    IDLE, MAC, STORE, DONE
  } state_t;

  state_t state, state_n;

  logic [31:0]      ibuf [IW];
  logic [31:0]      kbuf [KW];
  logic [ACC_W-1:0] obuf [OW];

  logic [15:0]      len, nout, c, k, n, idx;
  logic [3:0]       stride;
  logic [7:0]       off;
  logic             relu, valid;
  logic [ACC_W-1:0] bias, acc, sum, res;
  logic [6:0]       prev;
  logic [31:0]      ret_q, xa, wa, xw, ww;
  logic [7:0]       xs, ws;
  logic [8:0]       xo;
  logic [16:0]      prod;
  logic             busy, start, last_mac, cfg_wr;

  assign bus.ret = ret_q;
  assign bus.output_buffer_valid = valid;

  assign nout = (len >= 16'(KERNEL_LEN))
    ? (len - 16'(KERNEL_LEN)) / {12'd0, stride} + 16'd1
    : 16'd0;

  assign busy = (state == MAC) || (state == STORE);
  assign start = (bus.cmd == 7'd5) && (prev != 7'd5)
    && (state == IDLE);
  assign last_mac = (c == 16'(NUM_CH - 1))
    && (k == 16'(KERNEL_LEN - 1));
  assign cfg_wr = (bus.cmd == 7'd1) || (bus.cmd == 7'd2)
    || (bus.cmd == 7'd8) || (bus.cmd == 7'd9);

  // Low 17 bits of the product of sign-extended operands are
  // the signed product, so plain unsigned multiply suffices.
  always_comb begin
    idx  = n * {12'd0, stride} + k;
    xa   = 32'(c) * 32'(MAX_LEN / 4) + 32'(idx[15:2]);
    wa   = 32'(c) * 32'(KERNEL_LEN / 4) + 32'(k[15:2]);
    xw   = ibuf[xa[IA-1:0]];
    ww   = kbuf[wa[KA-1:0]];
    xs   = xw[{idx[1:0], 3'b000} +: 8];
    ws   = ww[{k[1:0], 3'b000} +: 8];
    xo   = {xs[7], xs} + {off[7], off};
    prod = {{8{xo[8]}}, xo} * {{9{ws[7]}}, ws};
    sum  = acc + {{(ACC_W-17){prod[16]}}, prod};
    res  = (relu && acc[ACC_W-1]) ? '0 : acc;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = (nout == 16'd0) ? DONE : MAC;
      MAC:   if (last_mac) state_n = STORE;
      STORE: state_n = (n == nout - 16'd1) ? DONE : MAC;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && !busy) begin
      if (bus.cmd == 7'd1 && bus.inp0 < 32'(IW))
        ibuf[bus.inp0[IA-1:0]] <= bus.inp1;
      if (bus.cmd == 7'd2 && bus.inp0 < 32'(KW))
        kbuf[bus.inp0[KA-1:0]] <= bus.inp1;
    end
    if (!reset && state == STORE)
      obuf[n[OA-1:0]] <= res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      valid  <= 1'b0;
      ret_q  <= '0;
      len    <= 16'(MAX_LEN);
      stride <= 4'd1;
      off    <= '0;
      relu   <= 1'b0;
      bias   <= '0;
      prev   <= '0;
      c      <= '0;
      k      <= '0;
      n      <= '0;
      acc    <= '0;
    end else begin
      state <= state_n;
      prev  <= bus.cmd;
      if (!busy) begin
        case (bus.cmd)
          7'd8: bias <= bus.inp0;
          7'd9: begin
            len <= (bus.inp0[15:0] > 16'(MAX_LEN))
              ? 16'(MAX_LEN) : bus.inp0[15:0];
            stride <= (bus.inp1[3:0] == 4'd0)
              ? 4'd1 : bus.inp1[3:0];
            off  <= bus.inp1[15:8];
            relu <= bus.inp1[16];
          end
          default: ;
        endcase
      end
      if (state == DONE)
        valid <= 1'b1;
      else if (start || (state == IDLE && cfg_wr))
        valid <= 1'b0;
      case (bus.cmd)
        7'd3: ret_q <= (!busy && bus.inp0 < 32'(nout))
          ? 32'(obuf[bus.inp0[OA-1:0]]) : 32'd0;
        7'd4: ret_q <= {nout, len};
        7'd6: ret_q <= (bus.inp0 < 32'(IW))
          ? ibuf[bus.inp0[IA-1:0]] : 32'd0;
        7'd7: ret_q <= (bus.inp0 < 32'(KW))
          ? kbuf[bus.inp0[KA-1:0]] : 32'd0;
        default: ;
      endcase
      unique case (state)
        IDLE: if (start) begin
          c   <= '0;
          k   <= '0;
          n   <= '0;
          acc <= bias;
        end
        MAC: begin
          acc <= sum;
          if (k == 16'(KERNEL_LEN - 1)) begin
            k <= '0;
            c <= c + 16'd1;
          end else begin
            k <= k + 16'd1;
          end
        end
        STORE: begin
          acc <= bias;
          c   <= '0;
          k   <= '0;
          n   <= n + 16'd1;
        end
        DONE: ;
        default: ;
      endcase
    end
  end
endmodule
